count_sequencer: RTL and testbench

//  Run controller for a 5-bit up-counter datapath. On a start pulse, loads a

---
 rtl/count_sequencer_if.sv | 24 ++
 rtl/count_sequencer.sv | 108 ++++++++++
 tb/tb_count_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Host-side bus of the count sequencer: run control inputs and counter status outputs.
interface count_sequencer_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  modport master (
    output start, load_val, term_val, pause, abort,
    input  count, busy, done, state
  );

  modport slave (
    input  start, load_val, term_val, pause, abort,
    output count, busy, done, state
  );
endinterface

// File: rtl/count_sequencer.sv
// Run controller for an up-counter: load preset, count to a captured terminal, pulse done.
// Optional COUNT_SEQ_AUTORELOAD_EN: DONE returns to LOAD and free-runs until abort.
//
// state | meaning
// IDLE  | waiting for start, count held
// LOAD  | one cycle, count takes the captured preset
// RUN   | counting up toward the captured terminal
// HOLD  | paused, count held
// DONE  | one cycle completion pulse
module count_sequencer #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(5'h11)
) (
  input logic              clk,
  input logic              reset,
  count_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] preset_q;
  logic [WIDTH-1:0] term_q;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: state_d = bus.abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.abort)                state_d = S_IDLE;
        else if (count_q == term_q)   state_d = S_DONE;
        else if (bus.pause)           state_d = S_HOLD;
        else                          state_d = S_RUN;
      end
      S_HOLD: begin
        if (bus.abort)       state_d = S_IDLE;
        else if (!bus.pause) state_d = S_RUN;
        else                 state_d = S_HOLD;
      end
      S_DONE: begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
        state_d = bus.abort ? S_IDLE : S_LOAD;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they can be registered alongside it.
  always_comb begin
    count_d = count_q;
    if (state_q == S_LOAD) begin
      count_d = preset_q;
    end else if (state_q == S_RUN && state_d == S_RUN) begin
      count_d = count_q + WIDTH'(1);
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= RESET_VAL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      preset_q <= '0;
      term_q   <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && bus.start) begin
        preset_q <= bus.load_val;
        term_q   <= bus.term_val;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: per-cycle scoreboard of state/count/busy/done.
module tb_count_sequencer;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
`ifdef COUNT_SEQ_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];
  logic [4:0] cur_count;

  count_sequencer_if #(.WIDTH(5)) bus ();

  count_sequencer #(.WIDTH(5), .RESET_VAL(5'h11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] s, input logic [4:0] c, input logic b, input logic d);
    obs_t r;
    r.st = s; r.cnt = c; r.busy = b; r.done = d;
    return r;
  endfunction

  function automatic obs_t observed();
    obs_t r;
    r.st = bus.state; r.cnt = bus.count; r.busy = bus.busy; r.done = bus.done;
    return r;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d cnt=%0d busy=%0b done=%0b", o.st, o.cnt, o.busy, o.done);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [4:0] l, input logic [4:0] t);
    bus.start    = 1'b1;
    bus.load_val = l;
    bus.term_val = t;
    exp_q.push_back(mk(LOAD, cur_count, 1'b1, 1'b0));
  endtask

  function automatic void push_done(input logic [4:0] t);
    exp_q.push_back(mk(DONE, t, 1'b1, 1'b1));
    if (AUTO) exp_q.push_back(mk(LOAD, t, 1'b1, 1'b0));
    else      exp_q.push_back(mk(IDLE, t, 1'b0, 1'b0));
  endfunction

  // With autoreload the block is left in LOAD; abort there parks it in IDLE holding the preset.
  task automatic settle(input logic [4:0] p, input logic [4:0] t);
    if (AUTO) begin
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      cur_count = p;
    end else begin
      cur_count = t;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    bus.start = 1'b0; bus.load_val = '0; bus.term_val = '0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    #10;
    reset = 1'b0;
    #1;
    o = observed();
    checks++; if (o.st !== IDLE)  begin failures++; $display("FAIL reset_state got %0d want 0", o.st); end
    checks++; if (o.cnt !== 5'h11) begin failures++; $display("FAIL reset_count got %0h want 11", o.cnt); end
    checks++; if (o.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", o.busy); end
    checks++; if (o.done !== 1'b0) begin failures++; $display("FAIL reset_done got %0b want 0", o.done); end
    cur_count = 5'h11;
    @(negedge clk);
  endtask

  task automatic test_basic_run();
    obs_t e, o;
    drive_start(5'd3, 5'd7);
    for (int c = 3; c <= 7; c++) exp_q.push_back(mk(RUN, 5'(c), 1'b1, 1'b0));
    push_done(5'd7);
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_run cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) bus.start = 1'b0;
    end
    settle(5'd3, 5'd7);
  endtask

  task automatic test_wrap_pause();
    obs_t e, o;
    drive_start(5'd30, 5'd1);
    exp_q.push_back(mk(RUN, 5'd30, 1'b1, 1'b0));
    exp_q.push_back(mk(RUN, 5'd31, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(HOLD, 5'd31, 1'b1, 1'b0));
    exp_q.push_back(mk(RUN, 5'd31, 1'b1, 1'b0));
    exp_q.push_back(mk(RUN, 5'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(RUN, 5'd1, 1'b1, 1'b0));
    push_done(5'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_pause cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) bus.start = 1'b0;
      if (i == 2) bus.pause = 1'b1;
      if (i == 5) bus.pause = 1'b0;
    end
    settle(5'd30, 5'd1);
  endtask

  task automatic test_equal_and_abort();
    obs_t e, o;
    drive_start(5'd5, 5'd5);
    exp_q.push_back(mk(RUN, 5'd5, 1'b1, 1'b0));
    push_done(5'd5);
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL equal_run cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) bus.start = 1'b0;
    end
    settle(5'd5, 5'd5);

    drive_start(5'd7, 5'd20);
    for (int c = 7; c <= 9; c++) exp_q.push_back(mk(RUN, 5'(c), 1'b1, 1'b0));
    exp_q.push_back(mk(IDLE, 5'd9, 1'b0, 1'b0));
    exp_q.push_back(mk(IDLE, 5'd9, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_pause cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) bus.start = 1'b0;
      if (i == 1) begin bus.start = 1'b1; bus.load_val = 5'd0; bus.term_val = 5'd0; end
      if (i == 2) bus.start = 1'b0;
      if (i == 3) begin bus.pause = 1'b1; bus.abort = 1'b1; end
      if (i == 4) begin bus.pause = 1'b0; bus.abort = 1'b0; end
    end
    cur_count = 5'd9;

    drive_start(5'd2, 5'd10);
    exp_q.push_back(mk(IDLE, 5'd2, 1'b0, 1'b0));
    exp_q.push_back(mk(IDLE, 5'd2, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort_load cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) begin bus.start = 1'b0; bus.abort = 1'b1; end
      if (i == 1) bus.abort = 1'b0;
    end
    cur_count = 5'd2;
  endtask

  task automatic test_reset_midrun();
    obs_t e, o;
    drive_start(5'd10, 5'd20);
    for (int c = 10; c <= 12; c++) exp_q.push_back(mk(RUN, 5'(c), 1'b1, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midrun cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0) bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    e = mk(IDLE, 5'h11, 1'b0, 1'b0);
    o = observed();
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL midrun_reset got %s want %s", fmt(o), fmt(e));
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL after_reset cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
    end
    cur_count = 5'h11;
  endtask

`ifdef COUNT_SEQ_AUTORELOAD_EN
  task automatic test_autoreload();
    obs_t e, o;
    drive_start(5'd2, 5'd4);
    for (int p = 0; p < 2; p++) begin
      for (int c = 2; c <= 4; c++) exp_q.push_back(mk(RUN, 5'(c), 1'b1, 1'b0));
      exp_q.push_back(mk(DONE, 5'd4, 1'b1, 1'b1));
      exp_q.push_back(mk(LOAD, 5'd4, 1'b1, 1'b0));
    end
    exp_q.push_back(mk(RUN, 5'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(RUN, 5'd3, 1'b1, 1'b0));
    exp_q.push_back(mk(IDLE, 5'd3, 1'b0, 1'b0));
    exp_q.push_back(mk(IDLE, 5'd3, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      tick();
      e = exp_q.pop_front();
      o = observed();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL autoreload cycle %0d: got %s want %s", i, fmt(o), fmt(e));
      end
      if (i == 0)  bus.start = 1'b0;
      if (i == 12) bus.abort = 1'b1;
      if (i == 13) bus.abort = 1'b0;
    end
    cur_count = 5'd3;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_run();
    test_wrap_pause();
    test_equal_and_abort();
    test_reset_midrun();
`ifdef COUNT_SEQ_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
